// File: rtl/sram_arb.sv
// sram_arb: two-requester arbiter and sequencer for a single-port, byte-writable
// 32-bit SRAM. Pipeline: accept (comb grant) -> issue (one SRAM cycle) -> respond
// (registered strobe to the owning port). Latency 2, one command per cycle.
// Build option: define SRAM_ARB_FIXED_PRIO_EN to make port 0 win every tie.
// Otherwise ties are broken round-robin.
module sram_arb #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    // requester 0
    input  logic                 req_valid_0,
    output logic                 req_ready_0,
    input  logic [ADDRWIDTH-1:0] req_addr_0,
    input  logic [DATAWIDTH/8-1:0] req_we_0,
    input  logic [DATAWIDTH-1:0] req_wdata_0,
    output logic                 rsp_valid_0,
    output logic [DATAWIDTH-1:0] rsp_rdata_0,
    // requester 1
    input  logic                 req_valid_1,
    output logic                 req_ready_1,
    input  logic [ADDRWIDTH-1:0] req_addr_1,
    input  logic [DATAWIDTH/8-1:0] req_we_1,
    input  logic [DATAWIDTH-1:0] req_wdata_1,
    output logic                 rsp_valid_1,
    output logic [DATAWIDTH-1:0] rsp_rdata_1,
    // SRAM side
    output logic                 mem_cs,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH/8-1:0] mem_we,
    output logic [DATAWIDTH-1:0] mem_wdata,
    input  logic [DATAWIDTH-1:0] mem_rdata,
    // statistics
    output logic [15:0]          conflict_cnt
);
    localparam int NB = DATAWIDTH / 8;

    typedef struct packed {
        logic                 port;
        logic [ADDRWIDTH-1:0] addr;
        logic [NB-1:0]        we;
        logic [DATAWIDTH-1:0] wdata;
    } cmd_t;

    logic       [1:0]                vld;
    logic       [1:0]                gnt;
    logic                            last_grant;
    cmd_t                            acc_cmd;
    cmd_t                            cmd_q;
    logic                            cmd_vld;
    logic       [1:0]                rsp_vld_q;
    logic       [1:0][DATAWIDTH-1:0] rsp_data_q;

    assign vld = {req_valid_1, req_valid_0};

    // Grant: a lone requester wins; on a tie the priority rule picks one.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (vld == 2'b11) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                gnt = 2'b01;
`else
                gnt = last_grant ? 2'b01 : 2'b10;
`endif
            end else begin
                gnt = vld;
            end
        end
    end

    assign req_ready_0 = gnt[0];
    assign req_ready_1 = gnt[1];

    // Remember who was granted last so the other side wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end
`ifdef SRAM_ARB_FIXED_PRIO_EN
        else begin
            last_grant <= 1'b1;
        end
`else
        else if (|gnt) begin
            last_grant <= gnt[1];
        end
`endif
    end

    // Mux the winning requester's fields into a command word.
    always_comb begin
        acc_cmd.port  = gnt[1];
        acc_cmd.addr  = gnt[1] ? req_addr_1  : req_addr_0;
        acc_cmd.we    = gnt[1] ? req_we_1    : req_we_0;
        acc_cmd.wdata = gnt[1] ? req_wdata_1 : req_wdata_0;
    end

    // Issue stage register: holds the accepted command for its SRAM cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_vld <= 1'b0;
            cmd_q   <= '0;
        end else begin
            cmd_vld <= |gnt;
            if (|gnt) begin
                cmd_q <= acc_cmd;
            end
        end
    end

    // rst kills the issue cycle combinationally so no write lands during reset.
    assign mem_cs    = cmd_vld & ~rst;
    assign mem_addr  = cmd_q.addr;
    assign mem_we    = mem_cs ? cmd_q.we : '0;
    assign mem_wdata = cmd_q.wdata;

    // Response stage: capture read data (or 0 for writes) for the owning port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            rsp_vld_q <= '0;
            if (mem_cs) begin
                rsp_vld_q[cmd_q.port]  <= 1'b1;
                rsp_data_q[cmd_q.port] <= (cmd_q.we == '0) ? mem_rdata : '0;
            end
        end
    end

    // A response still in flight when rst arrives is dropped, not delivered.
    assign rsp_valid_0 = rsp_vld_q[0] & ~rst;
    assign rsp_valid_1 = rsp_vld_q[1] & ~rst;
    assign rsp_rdata_0 = rsp_data_q[0];
    assign rsp_rdata_1 = rsp_data_q[1];

    // Count cycles where both requesters compete; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if ((vld == 2'b11) && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: SRAM model, reference memory + arbitration model, and a
// scoreboard monitor that checks issue and response cycles independently of stimulus.
module tb_sram_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  v;
    logic [15:0] a  [2];
    logic [3:0]  we [2];
    logic [31:0] wd [2];
    logic        rdy0, rdy1, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic        mem_cs;
    logic [15:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] conflict_cnt;

    always #5 clk = ~clk;

    sram_arb #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(v[0]), .req_ready_0(rdy0), .req_addr_0(a[0]), .req_we_0(we[0]),
        .req_wdata_0(wd[0]), .rsp_valid_0(rv0), .rsp_rdata_0(rd0),
        .req_valid_1(v[1]), .req_ready_1(rdy1), .req_addr_1(a[1]), .req_we_1(we[1]),
        .req_wdata_1(wd[1]), .rsp_valid_1(rv1), .rsp_rdata_1(rd1),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    // SRAM model: combinational read, byte-masked write on the clock edge.
    logic [31:0] sram [256] = '{default: 32'h0};
    assign mem_rdata = (mem_cs && mem_we == 4'h0) ? sram[mem_addr[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_cs === 1'b1)
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    typedef struct { int due; logic [15:0] addr; logic [3:0] we; logic [31:0] wdata; } iss_t;
    typedef struct { int due; logic [31:0] data; } rsp_t;
    iss_t        iss_q[$];
    rsp_t        rq0[$], rq1[$];
    logic [31:0] ref_mem [256] = '{default: 32'h0};
    int          cyc = 0;
    int          n_cmp = 0, n_bad = 0;
    int          m_conf = 0, m_last = 1;
    logic [1:0]  acc = 2'b00;
    logic [3:0]  gseq;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: apply the command to the reference memory in acceptance order
    // and queue the issue and response it must produce.
    task automatic accept(int p);
        iss_t e;
        rsp_t r;
        logic [31:0] w;
        w = ref_mem[a[p][7:0]];
        e.due = cyc + 1; e.addr = a[p]; e.we = we[p]; e.wdata = wd[p];
        iss_q.push_back(e);
        r.due = cyc + 2;
        if (we[p] == 4'h0) begin
            r.data = w;
        end else begin
            for (int b = 0; b < 4; b++) if (we[p][b]) w[8*b +: 8] = wd[p][8*b +: 8];
            ref_mem[a[p][7:0]] = w;
            r.data = 32'h0;
        end
        if (p == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    // One clock: check who may be accepted, record handshakes, advance.
    task automatic tick();
        int win;
        @(negedge clk);
        win = -1;
        if (!rst) begin
            if (v == 2'b11) begin
                if (m_conf < 65535) m_conf++;
`ifdef SRAM_ARB_FIXED_PRIO_EN
                win = 0;
`else
                win = (m_last == 1) ? 0 : 1;
`endif
            end else if (v[0]) win = 0;
            else if (v[1]) win = 1;
        end
        chk("ready0", rdy0, win == 0);
        chk("ready1", rdy1, win == 1);
        acc = {v[1] & rdy1, v[0] & rdy0};
        if (acc[0]) accept(0);
        if (acc[1]) accept(1);
        if (rst) begin
            m_last = 1;
            m_conf = 0;
        end
`ifdef SRAM_ARB_FIXED_PRIO_EN
`else
        else if (win >= 0) m_last = win;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int p, logic [15:0] ad, logic [3:0] w, logic [31:0] d);
        v[p] = 1'b1; a[p] = ad; we[p] = w; wd[p] = d;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (acc[p]) break;
        end
        if (!acc[p]) chk("accept_timeout", 32'd0, 32'd1);
        v[p] = 1'b0;
    endtask

    // Monitor: compare SRAM issue and response strobes against the scoreboard.
    always @(negedge clk) begin : mon
        iss_t e;
        rsp_t r;
        logic ex;
        if (rst !== 1'b0) begin
            iss_q.delete(); rq0.delete(); rq1.delete();
        end else begin
            ex = iss_q.size() > 0 && iss_q[0].due == cyc;
            chk("mem_cs", mem_cs, ex);
            if (ex) begin
                e = iss_q.pop_front();
                if (mem_cs) begin
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", mem_we, e.we);
                    chk("mem_wdata", mem_wdata, e.wdata);
                end
            end else chk("mem_we_idle", mem_we, 32'h0);
            ex = rq0.size() > 0 && rq0[0].due == cyc;
            chk("rsp_valid0", rv0, ex);
            if (ex) begin
                r = rq0.pop_front();
                if (rv0) chk("rsp_rdata0", rd0, r.data);
            end
            ex = rq1.size() > 0 && rq1[0].due == cyc;
            chk("rsp_valid1", rv1, ex);
            if (ex) begin
                r = rq1.pop_front();
                if (rv1) chk("rsp_rdata1", rd1, r.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        v = 2'b11;
        a[0] = 16'h5; a[1] = 16'h6; we[0] = 4'h0; we[1] = 4'h0; wd[0] = 32'h0; wd[1] = 32'h0;

        // reset held two cycles with both requesters valid
        tick();
        chk("rst_mem_cs", mem_cs, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", mem_we, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rsp_valid0", rv0, 32'h0);
        chk("rst_rsp_valid1", rv1, 32'h0);
        chk("rst_rsp_rdata0", rd0, 32'h0);
        chk("rst_rsp_rdata1", rd1, 32'h0);
        tick();
        chk("rst_conflict", conflict_cnt, 32'h0);
        rst = 1'b0;
        v = 2'b00;
        tick();

        // contention: both valid for 4 cycles, reads 0x1 / 0x2
        v = 2'b11; a[0] = 16'h1; a[1] = 16'h2; we[0] = 4'h0; we[1] = 4'h0;
        for (int k = 0; k < 4; k++) begin
            tick();
            gseq[k] = acc[1];
        end
`ifdef SRAM_ARB_FIXED_PRIO_EN
        chk("grant_seq", gseq, 32'h0);
`else
        chk("grant_seq", gseq, 32'hA);
`endif
        chk("conflict_4", conflict_cnt, 32'd4);
        v[0] = 1'b0;
        if (acc[1]) v[1] = 1'b0;
        for (int k = 0; k < 20 && v[1]; k++) begin
            tick();
            if (acc[1]) v[1] = 1'b0;
        end
        chk("drain_port1", v[1], 32'h0);
        repeat (3) tick();

        // single access, then back-to-back read of the same word
        issue(0, 16'h0010, 4'hF, 32'hDEADBEEF);
        issue(0, 16'h0010, 4'h0, 32'h0);
        tick(); tick();
        chk("single_rd", rd0, 32'hDEADBEEF);

        // byte lanes
        issue(0, 16'h0020, 4'hF, 32'h11223344);
        issue(0, 16'h0020, 4'b0101, 32'hAABBCCDD);
        issue(0, 16'h0020, 4'h0, 32'h0);
        tick(); tick();
        chk("byte_lanes", rd0, 32'h11BB33DD);

        // randomized traffic on a small address window to force hazards
        acc = 2'b00;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!v[p] || acc[p]) begin
                    if ($urandom_range(99) < 65) begin
                        v[p]  = 1'b1;
                        a[p]  = 16'($urandom_range(7));
                        we[p] = ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom_range(15));
                        wd[p] = $urandom();
                    end else v[p] = 1'b0;
                end
            end
            tick();
        end
        v = 2'b00;
        repeat (4) tick();
        chk("conflict_rand", conflict_cnt, m_conf);

        // reset mid-flight: read accepted in N, rst in N+1
        v[1] = 1'b1; a[1] = 16'h3; we[1] = 4'h0;
        tick();
        chk("mid_accept", acc[1], 32'h1);
        v[1] = 1'b0;
        rst = 1'b1;
        #2;
        chk("mid_mem_cs", mem_cs, 32'h0);
        tick();
        rst = 1'b0;
        chk("mid_rsp_valid1", rv1, 32'h0);
        repeat (3) tick();
        chk("conflict_after_rst", conflict_cnt, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_arb.md
# sram_arb

Two-requester arbiter and sequencer for the shared single-port 32-bit byte-writable SRAM. Accepts read/write commands from two masters over valid/ready handshakes, grants one per cycle (round-robin by default), drives the SRAM's chip-select/byte-enable/address/data for one cycle, and returns a registered response to the winning requester. It sits directly in front of the SRAM; the SRAM is the arbiter's only slave.

## Interface
Parameters:
- ADDRWIDTH, 16, SRAM word-address width.
- DATAWIDTH, 32, data width; fixed at 32 (4 byte lanes).

Ports (i = 0, 1 per requester):
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  command valid.
- req_ready_i  out  1  command accepted this cycle when high with req_valid_i.
- req_addr_i  in  ADDRWIDTH  word address.
- req_we_i  in  4  byte write enables; 4'h0 = read.
- req_wdata_i  in  32  write data.
- rsp_valid_i  out  1  one-cycle response strobe.
- rsp_rdata_i  out  32  read data; 0 for writes.
- mem_cs  out  1  SRAM chip select.
- mem_addr  out  ADDRWIDTH  SRAM address.
- mem_we  out  4  SRAM byte enables.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data (combinational, valid while mem_cs & mem_we==0).
- conflict_cnt  out  16  saturating count of cycles both requesters were valid.

## Operation
- Stage A (accept): req_ready_i is combinational from valids and priority state; at most one ready high per cycle; both low while rst is high.
- Round-robin: last_grant register (reset 1). One valid → it wins. Both valid → winner is the port != last_grant. last_grant updates to the winner on every accepted command.
- Stage B (issue): accepted command registered into cmd stage; next cycle mem_cs=1 with addr/we/wdata from that register; mem_cs=0 and mem_we=0 when stage empty. The SRAM commits writes on the posedge that ends the issue cycle.
- Stage C (respond): at end of issue cycle, mem_rdata (reads) or 0 (writes) captured into rsp_rdata of the owning port; owning rsp_valid high for exactly one cycle; other port's rsp_valid low, its rsp_rdata holds its last value.
- Writes acknowledged like reads (rsp_valid strobe). Partial writes use mem_we as given; unselected bytes are preserved by the SRAM.
- No backpressure on responses: requesters must sink rsp_valid unconditionally.
- Ordering: commands execute strictly in acceptance order; a read accepted the cycle after a write to the same address returns the new data.
- conflict_cnt increments each cycle both req_valid are high, saturates at 16'hFFFF, and clears on rst.

## Timing
- Accept in cycle N → mem_cs in N+1 → rsp_valid in N+2. Latency 2, throughput 1 command/cycle sustained.
- Reset values (after any rst cycle): req_ready 0 during rst, mem_cs 0, mem_addr 0, mem_we 0, mem_wdata 0, rsp_valid 0, rsp_rdata 0, last_grant 1, conflict_cnt 0.
- rst mid-operation: commands in Stage B/C are dropped; no rsp_valid issued for them; no SRAM write occurs in the rst cycle (mem_cs forced 0).
- Requester must hold req fields stable while valid & !ready.

## Configuration
- SRAM_ARB_FIXED_PRIO_EN defined: port 0 always wins when both are valid; last_grant is unused (held at reset value). Port 1 can starve.
- Undefined: round-robin as above.

## Test plan
- Reset: hold rst 2 cycles with both valid → all outputs at reset values, no mem_cs, conflict_cnt 0.
- Single access: port 0 write addr 0x0010, we 4'hF, data 0xDEADBEEF; then read 0x0010 → mem_cs in N+1, rsp_valid_0 in N+2 each time; rdata 0xDEADBEEF.
- Byte lanes: write 0x11223344 full, then we 4'b0101 data 0xAABBCCDD, read → 0x11BB33DD.
- Contention: both valid for 4 cycles, reads to 0x1/0x2 → grants 0,1,0,1; responses alternate with 2-cycle latency; conflict_cnt 4.
- Fixed priority (macro on): both valid 3 cycles → port 0 granted 3 times, req_ready_1 low throughout.
- Reset mid-flight: accept read in N, assert rst in N+1 → no rsp_valid in N+2, mem_cs 0 in N+1.
